perf_event_counters: RTL and testbench

- Synthesizable, parametrised performance-counter unit; next generation of the simulation-only instruction/cache-hit tallies.
- Sits beside the core (proc_hier level). Takes one-cycle event strobes (retired instruction, I$ req/hit, D$ req/hit, ...) plus halt.
- Keeps NUM_EVENTS event counters and one free-running cycle counter, with freeze-on-halt, clear, wrap or saturate mode, sticky overflow flags, and a registered read port.

---
 rtl/perf_pkg.sv | 17 +
 rtl/perf_counter_cell.sv | 50 +++++
 rtl/perf_event_counters.sv | 99 +++++++++
 tb/tb_perf_event_counters.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter unit: event slot indices and
// overflow-mode encodings.
package perf_pkg;

    localparam int unsigned EV_INST  = 0;
    localparam int unsigned EV_ICREQ = 1;
    localparam int unsigned EV_ICHIT = 2;
    localparam int unsigned EV_DCREQ = 3;
    localparam int unsigned EV_DCHIT = 4;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam int unsigned NUM_EVENTS_DEF = 5;
    localparam int unsigned CNT_W_DEF      = 32;

endpackage

// File: rtl/perf_counter_cell.sv
// One unsigned counter with soft clear, wrap-or-saturate overflow handling
// and a sticky overflow flag.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    // Clear dominates increment; all-ones + 1 either wraps or pins.
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (value_q == {CNT_W{1'b1}}) begin
                ovf_d   = 1'b1;
                value_d = (SATURATE == MODE_SAT) ? {CNT_W{1'b1}} : '0;
            end else begin
                value_d = value_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Performance-counter unit: NUM_EVENTS event counters plus a cycle counter,
// freeze-on-halt, soft clear, sticky overflow and a one-cycle read port.
module perf_event_counters
    import perf_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = NUM_EVENTS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned SATURATE   = MODE_WRAP,
    parameter int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  halt,
    input  logic                  clear,
    input  logic                  rd_req,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [NUM_EVENTS:0]   overflow,
    output logic                  halted
);

    logic                  halted_q, halted_d;
    logic [CNT_W-1:0]      rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  active_c;
    logic [NUM_EVENTS:0]   inc_c;
    logic [NUM_EVENTS:0]   ovf_c;
    logic [CNT_W-1:0]      cnt_val [NUM_EVENTS+1];
    logic [CNT_W-1:0]      rd_mux_c;

    // Top slot of inc_c is the cycle counter, which ticks on every active cycle.
    always_comb begin
        active_c = en & ~halted_q & ~clear;
        inc_c    = {active_c, event_i & {NUM_EVENTS{active_c}}};
    end

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_EVENTS; gi++) begin : g_cell
            perf_counter_cell #(
                .CNT_W    (CNT_W),
                .SATURATE (SATURATE)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .clr   (clear),
                .inc   (inc_c[gi]),
                .value (cnt_val[gi]),
                .ovf   (ovf_c[gi])
            );
        end
    endgenerate

    // Out-of-range selects read back as zero.
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned i = 0; i < NUM_EVENTS + 1; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux_c = cnt_val[i];
            end
        end
    end

    always_comb begin
        halted_d   = halted_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_req;
        if (clear) begin
            halted_d = 1'b0;
        end else if (active_c && halt) begin
            halted_d = 1'b1;
        end
        if (rd_req) begin
            rd_data_d = rd_mux_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            halted_q   <= halted_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = ovf_c;
    assign halted   = halted_q;

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: three configurations (32-bit wrap, 4-bit wrap,
// 4-bit saturate) share one stimulus stream and are checked against a cycle model.
module tb_perf_event_counters;
    import perf_pkg::*;

    localparam int unsigned NE = 5;
    localparam int unsigned NI = 3;

    logic          clk = 1'b0;
    logic          rst, en, halt, clear, rd_req;
    logic [NE-1:0] event_i;
    logic [2:0]    rd_sel;

    logic [31:0]   d0_rd_data;
    logic [3:0]    dw_rd_data, ds_rd_data;
    logic [NI-1:0] vld;
    logic [NI-1:0] hlt;
    logic [NE:0]   ovf [NI];

    always #5 clk = ~clk;

    perf_event_counters #(.NUM_EVENTS(NE), .CNT_W(32), .SATURATE(MODE_WRAP)) u_dut_def (
        .clk(clk), .rst(rst), .en(en), .event_i(event_i), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(d0_rd_data), .rd_valid(vld[0]),
        .overflow(ovf[0]), .halted(hlt[0]));

    perf_event_counters #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(MODE_WRAP)) u_dut_wrap (
        .clk(clk), .rst(rst), .en(en), .event_i(event_i), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(dw_rd_data), .rd_valid(vld[1]),
        .overflow(ovf[1]), .halted(hlt[1]));

    perf_event_counters #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(MODE_SAT)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en), .event_i(event_i), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(ds_rd_data), .rd_valid(vld[2]),
        .overflow(ovf[2]), .halted(hlt[2]));

    typedef struct {
        int unsigned inst;
        logic [31:0] data;
    } exp_t;

    exp_t            sb_q[$];
    int unsigned     cfg_w   [NI] = '{32, 4, 4};
    bit              cfg_sat [NI] = '{1'b0, 1'b0, 1'b1};
    longint unsigned m_cnt   [NI][NE+1];
    bit              m_ovf   [NI][NE+1];
    bit              m_halted[NI];
    logic [31:0]     m_rd    [NI];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input int unsigned k);
        case (k)
            0:       return d0_rd_data;
            1:       return {28'd0, dw_rd_data};
            default: return {28'd0, ds_rd_data};
        endcase
    endfunction

    function automatic logic [31:0] ovf_exp(input int unsigned k);
        logic [31:0] v = '0;
        for (int j = 0; j <= NE; j++) v[j] = m_ovf[k][j];
        return v;
    endfunction

    // Advance the model with the inputs of this cycle, clock once, then compare.
    task automatic tick();
        longint unsigned maxv;
        bit              active, inc;
        exp_t            e;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                for (int j = 0; j <= NE; j++) begin
                    m_cnt[k][j] = 0;
                    m_ovf[k][j] = 1'b0;
                end
                m_halted[k] = 1'b0;
                m_rd[k]     = '0;
            end else begin
                if (rd_req) begin
                    e.inst = k;
                    e.data = (rd_sel <= 3'(NE)) ? 32'(m_cnt[k][rd_sel]) : 32'd0;
                    m_rd[k] = e.data;
                    sb_q.push_back(e);
                end
                maxv   = (64'd1 << cfg_w[k]) - 64'd1;
                active = en && !m_halted[k] && !clear;
                if (clear) begin
                    for (int j = 0; j <= NE; j++) begin
                        m_cnt[k][j] = 0;
                        m_ovf[k][j] = 1'b0;
                    end
                    m_halted[k] = 1'b0;
                end else if (active) begin
                    for (int j = 0; j <= NE; j++) begin
                        inc = (j == NE) ? 1'b1 : event_i[j];
                        if (inc) begin
                            if (m_cnt[k][j] == maxv) begin
                                m_ovf[k][j] = 1'b1;
                                m_cnt[k][j] = cfg_sat[k] ? maxv : 0;
                            end else begin
                                m_cnt[k][j] = m_cnt[k][j] + 1;
                            end
                        end
                    end
                    if (halt) m_halted[k] = 1'b1;
                end
            end
        end
        if (rst) sb_q.delete();
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (sb_q.size() > 0 && sb_q[0].inst == k) begin
                e = sb_q.pop_front();
                check_eq($sformatf("rd_valid[%0d]", k), 32'(vld[k]), 32'd1);
                check_eq($sformatf("rd_data[%0d]", k), rd_of(k), e.data);
            end else begin
                check_eq($sformatf("rd_valid_idle[%0d]", k), 32'(vld[k]), 32'd0);
                check_eq($sformatf("rd_data_hold[%0d]", k), rd_of(k), m_rd[k]);
            end
            check_eq($sformatf("overflow[%0d]", k), 32'(ovf[k]), ovf_exp(k));
            check_eq($sformatf("halted[%0d]", k), 32'(hlt[k]), 32'(m_halted[k]));
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [NE-1:0] ev,
                         input logic h, input logic c, input logic rq, input logic [2:0] s);
        rst = r; en = e; event_i = ev; halt = h; clear = c; rd_req = rq; rd_sel = s;
        tick();
    endtask

    task automatic rd(input logic [2:0] s);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, s);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; event_i = '0; halt = 1'b0; clear = 1'b0;
        rd_req = 1'b0; rd_sel = '0;
        tick();
        tick();

        // Basic count: 7 pulses on event 0, 3 on event 2, over 20 enabled cycles.
        for (int c = 0; c < 20; c++) begin
            logic [NE-1:0] ev;
            ev    = '0;
            ev[0] = (c < 7);
            ev[2] = (c % 5 == 0) && (c < 15);
            drive(1'b0, 1'b1, ev, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        rd(3'd0); rd(3'd2); rd(3'd5);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Halt freeze: halt on the 10th event cycle, then keep strobing.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
        for (int c = 0; c < 10; c++)
            drive(1'b0, 1'b1, 5'b00001, (c == 9), 1'b0, 1'b0, 3'd0);
        for (int c = 0; c < 5; c++)
            drive(1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, (c >= 3), (c == 3) ? 3'd0 : 3'd5);
        drive(1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0);

        // Overflow: 17 pulses on event 1 and 20 on event 3.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
        for (int c = 0; c < 20; c++) begin
            logic [NE-1:0] ev;
            ev    = '0;
            ev[1] = (c < 17);
            ev[3] = 1'b1;
            drive(1'b0, 1'b1, ev, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        rd(3'd1); rd(3'd3); rd(3'd5);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Clear precedence: counter0 at 9, then clear + all events + read.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
        for (int c = 0; c < 9; c++)
            drive(1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 5'b11111, 1'b1, 1'b1, 1'b1, 3'd0);
        for (int s = 0; s <= NE; s++) rd(3'(s));
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset mid-read, request during reset, then an out-of-range select.
        for (int c = 0; c < 4; c++)
            drive(1'b0, 1'b1, 5'b10101, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 5'b10101, 1'b0, 1'b0, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 5'b10101, 1'b0, 1'b0, 1'b1, 3'd2);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
        rd(3'd0); rd(3'd7); rd(3'd6);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Random traffic with occasional halt, clear and reset.
        for (int c = 0; c < 300; c++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
                  NE'($urandom), ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 3), 1'($urandom),
                  3'($urandom_range(0, 7)));
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
